// File: rtl/joy_serial_scanner_if.sv
// rtl/joy_serial_scanner_if.sv - joystick shift-chain pins and deserialised outputs
interface joy_serial_scanner_if #(
    parameter int WIDTH = 16
);
    logic             joy_clk;
    logic             joy_load;
    logic             joy_data;
    logic [WIDTH-1:0] joy_out;
    logic [WIDTH-1:0] joy_raw;
    logic             frame_done;

    modport master (
        output joy_clk, joy_load, joy_out, joy_raw, frame_done,
        input  joy_data
    );

    modport slave (
        input  joy_clk, joy_load, joy_out, joy_raw, frame_done,
        output joy_data
    );
endinterface

// File: rtl/joy_serial_scanner.sv
// rtl/joy_serial_scanner.sv - free-running joystick shift-chain reader with per-bit frame debounce
module joy_serial_scanner #(
    parameter int NUM_PLAYERS     = 2,
    parameter int BITS_PER_PLAYER = 8,
    parameter int CLK_DIV_LOG2    = 8,
    parameter int DEBOUNCE_FRAMES = 2,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    joy_serial_scanner_if.master  bus
);
    localparam int N     = NUM_PLAYERS * BITS_PER_PLAYER;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0]     IDLE     = {N{ACTIVE_LOW}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [3:0]       DB_LIM   = 4'(DEBOUNCE_FRAMES);

    logic [CLK_DIV_LOG2-1:0] div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N-1:0]            sh_q, sh_d;
    logic [N-1:0]            raw_q, raw_d;
    logic [N-1:0]            out_q, out_d;
    logic [3:0]              cnt_q [N];
    logic [3:0]              cnt_d [N];
    logic                    done_q, done_d;
    logic                    tick, last;

    always_comb begin
        div_d  = div_q + 1'b1;
        tick   = (div_q == '0);
        last   = tick && (idx_q == LAST_IDX);
        idx_d  = idx_q;
        sh_d   = sh_q;
        raw_d  = raw_q;
        out_d  = out_q;
        done_d = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        // First slot of a frame lands in the MSB of the highest player word
        if (tick) begin
            sh_d[LAST_IDX - idx_q] = bus.joy_data;
            idx_d = last ? '0 : idx_q + 1'b1;
        end

        if (last) begin
            raw_d  = sh_d;
            done_d = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (sh_d[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] + 4'd1 >= DB_LIM) begin
                    out_d[i] = sh_d[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            idx_q  <= '0;
            sh_q   <= IDLE;
            raw_q  <= IDLE;
            out_q  <= IDLE;
            done_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            sh_q   <= sh_d;
            raw_q  <= raw_d;
            out_q  <= out_d;
            done_q <= done_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Shift clock taken straight from the divider so it has no skew against tick
    assign bus.joy_clk    = div_q[CLK_DIV_LOG2-1];
    assign bus.joy_load   = (idx_q != '0);
    assign bus.joy_raw    = raw_q;
    assign bus.joy_out    = out_q;
    assign bus.frame_done = done_q;
endmodule
